// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial W-bit subtractor, D = A - B - Bin, LSB first.
// One full-subtractor cell plus a borrow flop handles one bit per clock.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start          request, accepted only in IDLE
//   A, B, Bin      minuend, subtrahend, borrow-in (captured on accept)
//   D, Bout        difference and borrow-out, held until the next accept
//   busy           high while bits are being processed
//   done           one-cycle pulse when D/Bout are valid
module serial_subtractor #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bin,
    output logic [W-1:0] D,
    output logic         Bout,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CNT_W = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_sh_q, a_sh_d;
    logic [W-1:0]       b_sh_q, b_sh_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       d_q, d_d;
    logic               bout_q, bout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               a0, b0, diff_bit, br_next, last_bit;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        a0       = a_sh_q[0];
        b0       = b_sh_q[0];
        diff_bit = a0 ^ b0 ^ br_q;
        br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        last_bit = (cnt_q == CNT_W'(W - 1));
    end

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output logic; busy/done are decoded from the next state
    // so that they come straight out of flops.
    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
        d_d    = d_q;
        bout_d = bout_q;
        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d = A;
                    b_sh_d = B;
                    br_d   = Bin;
                    cnt_d  = '0;
                    d_d    = '0;
                end
            end
            S_SHIFT: begin
                a_sh_d = {1'b0, a_sh_q[W-1:1]};
                b_sh_d = {1'b0, b_sh_q[W-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CNT_W'(1);
                // Result enters at the MSB so the LSB lands at bit 0 after W shifts.
                d_d    = {diff_bit, d_q[W-1:1]};
                if (last_bit) bout_d = br_next;
            end
            default: ;
        endcase
    end

    assign D    = d_q;
    assign Bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed W=4 cases and random W=8
// operations checked against an integer-arithmetic reference model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, sel8;
    logic [7:0] a_in, b_in;
    logic       bin_in;

    logic [3:0] d4;
    logic       bout4, busy4, done4;
    logic [7:0] d8;
    logic       bout8, busy8, done8;

    logic [7:0] d_s;
    logic       bout_s, busy_s, done_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel8),
        .A(a_in[3:0]), .B(b_in[3:0]), .Bin(bin_in),
        .D(d4), .Bout(bout4), .busy(busy4), .done(done4)
    );

    serial_subtractor #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start & sel8),
        .A(a_in), .B(b_in), .Bin(bin_in),
        .D(d8), .Bout(bout8), .busy(busy8), .done(done8)
    );

    assign d_s    = sel8 ? d8 : {4'b0, d4};
    assign bout_s = sel8 ? bout8 : bout4;
    assign busy_s = sel8 ? busy8 : busy4;
    assign done_s = sel8 ? done8 : done4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic, reduced modulo 2^w.
    function automatic logic [8:0] ref_sub(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
        int diff, mask;
        diff = int'(a) - int'(b) - int'(bin);
        mask = (1 << w) - 1;
        return {(diff < 0) ? 1'b1 : 1'b0, 8'(diff & mask)};
    endfunction

    // Issue one operation and verify latency, busy length, result and hold.
    task automatic run_op(input string tag, input int w, input logic [7:0] a,
                          input logic [7:0] b, input logic bin, input bit full);
        int cycles, busy_cnt;
        logic [8:0] exp;
        exp = ref_sub(w, a, b, bin);
        @(negedge clk);
        sel8 = (w == 8); a_in = a; b_in = b; bin_in = bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a_in = ~a; b_in = ~b; bin_in = ~bin;
        cycles = 0; busy_cnt = 0;
        while (!done_s && cycles < 40) begin
            if (busy_s) busy_cnt++;
            cycles++;
            @(negedge clk);
        end
        check({tag, ".done"}, 32'(done_s), 32'd1);
        check({tag, ".D"}, 32'(d_s), 32'(exp[7:0]));
        check({tag, ".Bout"}, 32'(bout_s), 32'(exp[8]));
        if (full) begin
            check({tag, ".lat"}, 32'(cycles), 32'(w));
            check({tag, ".busy"}, 32'(busy_cnt), 32'(w));
            check({tag, ".done_busy"}, 32'(busy_s), 32'd0);
            @(negedge clk);
            check({tag, ".done_pulse"}, 32'(done_s), 32'd0);
            @(negedge clk);
            check({tag, ".D_hold"}, 32'(d_s), 32'(exp[7:0]));
            check({tag, ".Bout_hold"}, 32'(bout_s), 32'(exp[8]));
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc, n_done, last_idx;
        logic [8:0] exp;
        rst_n = 1'b0; start = 1'b0; sel8 = 1'b0;
        a_in = '0; b_in = '0; bin_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst.D4", 32'(d4), 32'd0);
        check("rst.Bout4", 32'(bout4), 32'd0);
        check("rst.busy4", 32'(busy4), 32'd0);
        check("rst.done4", 32'(done4), 32'd0);
        check("rst.D8", 32'(d8), 32'd0);
        check("rst.busy8", 32'(busy8), 32'd0);

        run_op("t1", 4, 8'h5, 8'h3, 1'b0, 1'b1);
        run_op("t2", 4, 8'h3, 8'h5, 1'b0, 1'b1);
        run_op("t3", 4, 8'h0, 8'h0, 1'b1, 1'b1);

        // Start pulse during SHIFT must be ignored.
        @(negedge clk);
        sel8 = 1'b0; a_in = 8'hF; b_in = 8'h0; bin_in = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; a_in = 8'h1;
        @(negedge clk); start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 16; i++) begin
            if (done4) begin
                n_done++;
                check("ign.D", 32'(d4), 32'hF);
                check("ign.Bout", 32'(bout4), 32'd0);
            end
            @(negedge clk);
        end
        check("ign.pulses", 32'(n_done), 32'd1);

        // Reset in the middle of SHIFT aborts the operation.
        @(negedge clk);
        sel8 = 1'b0; a_in = 8'h8; b_in = 8'h1; bin_in = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("abort.D", 32'(d4), 32'd0);
        check("abort.Bout", 32'(bout4), 32'd0);
        check("abort.busy", 32'(busy4), 32'd0);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done4) n_done++;
            @(negedge clk);
        end
        check("abort.no_done", 32'(n_done), 32'd0);
        run_op("t4", 4, 8'h8, 8'h1, 1'b0, 1'b1);

        // Start held high: one operation every W+2 cycles.
        @(negedge clk);
        sel8 = 1'b0; a_in = 8'h6; b_in = 8'h2; bin_in = 1'b0; start = 1'b1;
        n_done = 0; last_idx = -1;
        for (cyc = 0; cyc < 32; cyc++) begin
            @(negedge clk);
            if (done4) begin
                check("b2b.D", 32'(d4), 32'h4);
                check("b2b.Bout", 32'(bout4), 32'd0);
                if (last_idx >= 0) check("b2b.gap", 32'(cyc - last_idx), 32'd6);
                last_idx = cyc;
                n_done++;
            end
        end
        start = 1'b0;
        check("b2b.count", 32'(n_done >= 4), 32'd1);
        repeat (8) @(negedge clk);

        // W=8 spot check and random operations.
        run_op("s8", 8, 8'h00, 8'hFF, 1'b0, 1'b1);
        exp = ref_sub(8, 8'h00, 8'hFF, 1'b0);
        check("s8.model", 32'(exp), 32'h101);
        run_op("e8a", 8, 8'hFF, 8'hFF, 1'b1, 1'b1);
        run_op("e8b", 8, 8'h80, 8'h7F, 1'b0, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            run_op("r8", 8, 8'($urandom), 8'($urandom), 1'($urandom), (i % 50) == 0);
        end
        for (int i = 0; i < 100; i++) begin
            run_op("r4", 4, 8'($urandom_range(15)), 8'($urandom_range(15)), 1'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
